// File: rtl/pwm_ramp_ctrl_if.sv
// rtl/pwm_ramp_ctrl_if.sv - AXI4-Lite write channel bundle used by pwm_ramp_ctrl
//
// Carries the AW, W and B channels between the ramp controller (master)
// and the PWM register bank (slave). Read channels are not present.
//   ADDR_WIDTH : AWADDR width in bits
//   master     : drives AW*/W*/BREADY, samples AWREADY/WREADY/BRESP/BVALID
//   slave      : the mirror image

interface pwm_ramp_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [2:0]            AWPROT;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - round-robin duty-cycle ramp sequencer over an AXI4-Lite write port
//
// Each channel keeps current/target/step and a pending bit. A ramp tick
// marks every channel that has not reached its target; the FSM then writes
// one step per pending channel, round-robin, one AXI write at a time.
//   ACLK, ARESET  : clock, synchronous active-high reset
//   CMD_*         : per-channel target/step command (step 0 = jump at once)
//   BUSY          : per channel, ramp still in progress
//   ERR           : sticky, set by any non-OKAY write response
//   M_AXI         : AXI4-Lite write master (AW/W/B)

module pwm_ramp_ctrl #(
    parameter int C_NUM_PWM    = 4,
    parameter int C_BASE_ADDR  = 'h100,
    parameter int C_ADDR_WIDTH = 10,
    parameter int C_TICK_DIV   = 1000,
    localparam int CH_W        = (C_NUM_PWM > 1) ? $clog2(C_NUM_PWM) : 1,
    localparam int TK_W        = $clog2(C_TICK_DIV)
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [CH_W-1:0]      CMD_CHANNEL,
    input  logic [23:0]          CMD_TARGET,
    input  logic [23:0]          CMD_STEP,
    output logic [C_NUM_PWM-1:0] BUSY,
    output logic                 ERR,
    pwm_ramp_ctrl_if.master      M_AXI
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR_DATA, S_WAIT_B} state_t;

    state_t                  state_q, state_d;
    logic [23:0]             cur_q [C_NUM_PWM];
    logic [23:0]             cur_d [C_NUM_PWM];
    logic [23:0]             tgt_q [C_NUM_PWM];
    logic [23:0]             tgt_d [C_NUM_PWM];
    logic [23:0]             stp_q [C_NUM_PWM];
    logic [23:0]             stp_d [C_NUM_PWM];
    logic [C_NUM_PWM-1:0]    pend_q, pend_d;
    logic [CH_W-1:0]         rr_q, rr_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [23:0]             nxt_q, nxt_d;
    logic                    awv_q, awv_d;
    logic                    wv_q, wv_d;
    logic                    brdy_q, brdy_d;
    logic                    err_q, err_d;
    logic [TK_W-1:0]         tick_q, tick_d;

    logic                    tick_wrap;
    logic                    sel_found;
    logic [CH_W-1:0]         sel_ch;

    function automatic logic [CH_W-1:0] wrap_ch(input int v);
        return CH_W'(v % C_NUM_PWM);
    endfunction

    // Saturating move toward target: the last step lands exactly on target.
    function automatic logic [23:0] ramp_next(input logic [23:0] cur,
                                              input logic [23:0] tgt,
                                              input logic [23:0] stp);
        logic [23:0] diff;
        diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        if (stp == 24'd0 || diff <= stp) return tgt;
        else if (tgt > cur)              return cur + stp;
        else                             return cur - stp;
    endfunction

    assign tick_wrap = (tick_q == TK_W'(C_TICK_DIV - 1));

    // First pending channel at or after the round-robin pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = 0; i < C_NUM_PWM; i++) begin
            if (!sel_found && pend_q[wrap_ch(int'(rr_q) + i)]) begin
                sel_found = 1'b1;
                sel_ch    = wrap_ch(int'(rr_q) + i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        stp_d   = stp_q;
        pend_d  = pend_q;
        rr_d    = rr_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        nxt_d   = nxt_q;
        awv_d   = awv_q;
        wv_d    = wv_q;
        brdy_d  = brdy_q;
        err_d   = err_q;
        tick_d  = tick_wrap ? '0 : tick_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    ch_d    = sel_ch;
                    addr_d  = C_ADDR_WIDTH'(C_BASE_ADDR + 4 * int'(sel_ch));
                    nxt_d   = ramp_next(cur_q[sel_ch], tgt_q[sel_ch], stp_q[sel_ch]);
                    awv_d   = 1'b1;
                    wv_d    = 1'b1;
                    state_d = S_ADDR_DATA;
                end
            end
            S_ADDR_DATA: begin
                if (M_AXI.AWREADY) awv_d = 1'b0;
                if (M_AXI.WREADY)  wv_d  = 1'b0;
                if (!awv_d && !wv_d) begin
                    brdy_d  = 1'b1;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (M_AXI.BVALID) begin
                    // Value is committed even on an error response.
                    cur_d[ch_q]  = nxt_q;
                    pend_d[ch_q] = 1'b0;
                    rr_d         = wrap_ch(int'(ch_q) + 1);
                    brdy_d       = 1'b0;
                    if (M_AXI.BRESP != 2'b00) err_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Applied after the commit so a jump command to the in-flight
        // channel is not lost when its pending bit is cleared.
        if (CMD_VALID && CMD_READY && (int'(CMD_CHANNEL) < C_NUM_PWM)) begin
            tgt_d[CMD_CHANNEL] = CMD_TARGET;
            stp_d[CMD_CHANNEL] = CMD_STEP;
            if (CMD_STEP == 24'd0) pend_d[CMD_CHANNEL] = 1'b1;
        end

        // Uses post-command target and post-commit current.
        if (tick_wrap) begin
            for (int i = 0; i < C_NUM_PWM; i++) begin
                if (cur_d[i] != tgt_d[i]) pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            cur_q   <= '{default: '0};
            tgt_q   <= '{default: '0};
            stp_q   <= '{default: '0};
            pend_q  <= '0;
            rr_q    <= '0;
            ch_q    <= '0;
            addr_q  <= '0;
            nxt_q   <= '0;
            awv_q   <= 1'b0;
            wv_q    <= 1'b0;
            brdy_q  <= 1'b0;
            err_q   <= 1'b0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            stp_q   <= stp_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            nxt_q   <= nxt_d;
            awv_q   <= awv_d;
            wv_q    <= wv_d;
            brdy_q  <= brdy_d;
            err_q   <= err_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        BUSY = '0;
        for (int i = 0; i < C_NUM_PWM; i++) begin
            BUSY[i] = (cur_q[i] != tgt_q[i]) || pend_q[i] ||
                      ((state_q != S_IDLE) && (ch_q == CH_W'(i)));
        end
    end

    assign CMD_READY     = ~ARESET;
    assign ERR           = err_q;
    assign M_AXI.AWADDR  = addr_q;
    assign M_AXI.AWPROT  = 3'b000;
    assign M_AXI.AWVALID = awv_q;
    assign M_AXI.WDATA   = {8'h00, nxt_q};
    assign M_AXI.WSTRB   = 4'hF;
    assign M_AXI.WVALID  = wv_q;
    assign M_AXI.BREADY  = brdy_q;

endmodule
